key_renderer: RTL and testbench
===============================

Name: key_renderer

Overview:
- Drawing engine between the synthesizer's key inputs and the 160x120 VGA frame-buffer adapter.
- Watches the synchronised key state and redraws, one pixel per cycle, the on-screen rectangle of each key whose pressed/released state changed.
- Drives the adapter's x/y/colour/plot write port.
- After reset it paints every key once, in released colour.

Parameters:
- NUM_KEYS, 4, number of on-screen keys; NUM_KEYS*KEY_W <= 160.
- KEY_W, 40, key rectangle width in pixels.
- KEY_H, 100, key rectangle height in pixels; KEY_Y0+KEY_H <= 120.
- KEY_Y0, 10, top row of every key rectangle.
- IDLE_COLOUR, 3'b111, fill colour of a released key.
- PRESS_COLOUR, 3'b010, fill colour of a pressed key.
- BORDER_COLOUR, 3'b000, colour of each key's leftmost column.

Ports:
- clock  in  1  system clock, CLOCK_50 domain.
- reset  in  1  asynchronous, active-high reset.
- keys  in  NUM_KEYS  raw key levels, 1 = pressed; asynchronous to clock.
- x  out  8  pixel column to adapter.
- y  out  7  pixel row to adapter.
- colour  out  3  pixel colour to adapter.
- plot  out  1  write strobe, one pixel per high cycle.
- busy  out  1  high while INIT or DRAW is active.

Behaviour:
- Reset values: x=0, y=0, colour=0, plot=0, busy=1 (INIT pending), drawn state=all 0, sync flops=0, state=INIT.
- keys pass through a 2-flop synchroniser. No debounce.
- Key k rectangle: x in [k*KEY_W, k*KEY_W+KEY_W-1], y in [KEY_Y0, KEY_Y0+KEY_H-1].
- Raster order inside a rectangle: x is the inner loop, y the outer loop.
- Outputs x/y/colour/plot are registered. Exactly one pixel is plotted per cycle while drawing, with no gaps.
- INIT state:
  - Draws keys 0..NUM_KEYS-1 back to back in IDLE_COLOUR.
  - Total plot cycles = NUM_KEYS*KEY_W*KEY_H (16000 at defaults).
  - Then goes to SCAN with drawn state = 0.
- SCAN state:
  - diff = sync_keys XOR drawn.
  - If diff is 0, stay in SCAN with plot=0 and busy=0.
  - Otherwise select the lowest-index set bit k. Latch target = sync_keys[k]. Go to DRAW with the pixel counters at the key's origin.
- DRAW state:
  - Fill colour = PRESS_COLOUR if target, else IDLE_COLOUR.
  - On the last pixel (x=key end, y=KEY_Y0+KEY_H-1): drawn[k] <= target, then go to SCAN.
- Latency: a stable key change present at the input before rising edge 0 gives plot=1 after edge 3, when the engine is idle.
- Simultaneous changes: serviced in ascending key order, one full rectangle each, with one SCAN cycle between rectangles.
- Change on key k during its own DRAW: the current rectangle completes with its latched colour. The next SCAN detects the mismatch and redraws.
- Press shorter than the redraw time: a press+release entirely during another key's draw is lost; correct by design, because the final screen matches the final key state.
- Reset mid-draw: plot=0 and busy=1 immediately (asynchronous), then INIT restarts from pixel 0.
- Coordinate arithmetic:
  - Pixel counters are 8-bit x and 7-bit y.
  - Rectangle origins are constants computed from the parameters; no multiplier in the datapath.
  - Counters never exceed the rectangle bounds, so there is no wrap-around.

Optional Feature:
- Macro: KEY_RENDER_BORDER_EN.
- Defined: the pixel with x == k*KEY_W (leftmost column of each key) uses BORDER_COLOUR in both INIT and DRAW.
- Undefined: the whole rectangle uses the fill colour, and BORDER_COLOUR is unused.

Decomposition:
- Package synth_gui_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3.
  - Colour constants: WHITE, GREEN, BLACK.
  - State enum: INIT, SCAN, DRAW.
- Sub-module key_rect_walker generates the raster x/y for one rectangle.
  - Inputs: start, x0.
  - Outputs: x, y, last.

Test Plan:
- Reset release with keys=0: exactly 16000 plot pulses, every x 0..159 / y 10..109 hit once, colour 3'b111 (3'b000 at x=0,40,80,120 with KEY_RENDER_BORDER_EN); then busy=0, plot=0.
- After init, keys=4'b0100: plot high after edge 3; 4000 pixels with x 80..119, y 10..109, colour 3'b010; then busy=0.
- keys 4'b0000->4'b1001 in one cycle: key0 (x 0..39) drawn first, one idle cycle, then key3 (x 120..159), both 3'b010.
- Press key1, release after 1000 plots of its redraw: 4000 pixels of 3'b010, then 4000 pixels of 3'b111, final drawn=0.
- Assert reset after 2000 plots of a DRAW: plot=0 in the same cycle; after release, 16000-pixel INIT repeats.
- Compile without KEY_RENDER_BORDER_EN, press key0: pixel x=0,y=10 has colour 3'b010.

Source files
------------

// File: rtl/synth_gui_pkg.sv
// Shared screen geometry, colour constants and engine state encoding for the
// synthesizer GUI drawing blocks.
package synth_gui_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        SCAN = 2'd1,
        DRAW = 2'd2
    } state_t;

endpackage

// File: rtl/key_rect_walker.sv
// Raster walker for one key rectangle: x inner loop, y outer loop, starting at
// (x0, KEY_Y0). Resets pointing at the origin of key 0.
module key_rect_walker
    import synth_gui_pkg::*;
#(
    parameter int unsigned KEY_W  = 40,
    parameter int unsigned KEY_H  = 100,
    parameter int unsigned KEY_Y0 = 10
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    input  logic [X_W-1:0] x0,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_SPAN  = X_W'(KEY_W - 1);
    localparam logic [Y_W-1:0] Y_FIRST = Y_W'(KEY_Y0);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(KEY_Y0 + KEY_H - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [X_W-1:0] x_end_q, x_end_d;

    assign last = (x_q == x_end_q) && (y_q == Y_LAST);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x_end_d = x_end_q;
        if (start) begin
            x_d     = x0;
            y_d     = Y_FIRST;
            x_end_d = x0 + X_SPAN;
        end else if (step && !last) begin
            if (x_q == x_end_q) begin
                x_d = x_end_q - X_SPAN;
                y_d = y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= Y_FIRST;
            x_end_q <= X_SPAN;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x_end_q <= x_end_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/key_renderer.sv
// Key drawing engine: paints all keys after reset, then redraws each key whose
// synchronised state differs from what is on screen. Optional macro
// KEY_RENDER_BORDER_EN paints each key's leftmost column in BORDER_COLOUR.
module key_renderer
    import synth_gui_pkg::*;
#(
    parameter int unsigned          NUM_KEYS      = 4,
    parameter int unsigned          KEY_W         = 40,
    parameter int unsigned          KEY_H         = 100,
    parameter int unsigned          KEY_Y0        = 10,
    parameter logic [COLOUR_W-1:0]  IDLE_COLOUR   = WHITE,
    parameter logic [COLOUR_W-1:0]  PRESS_COLOUR  = GREEN,
    parameter logic [COLOUR_W-1:0]  BORDER_COLOUR = BLACK
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy
);

    localparam int unsigned K_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] drawn_q, drawn_d, diff;
    logic [K_W-1:0]      k_q, k_d;
    logic                target_q, target_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, fill;
    logic                plot_q, plot_d, busy_q, busy_d;
    logic                walk_start, walk_step, drawing, border_pix;
    logic [X_W-1:0]      wx, origin_cur, origin_nxt;
    logic [Y_W-1:0]      wy;
    logic                wlast;

    key_rect_walker #(
        .KEY_W  (KEY_W),
        .KEY_H  (KEY_H),
        .KEY_Y0 (KEY_Y0)
    ) u_walker (
        .clock (clock),
        .reset (reset),
        .start (walk_start),
        .step  (walk_step),
        .x0    (origin_nxt),
        .x     (wx),
        .y     (wy),
        .last  (wlast)
    );

    // Rectangle origins are elaboration-time constants selected by key index.
    always_comb begin
        origin_cur = '0;
        origin_nxt = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k_q == K_W'(i)) origin_cur = X_W'(i * KEY_W);
            if (k_d == K_W'(i)) origin_nxt = X_W'(i * KEY_W);
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        target_d   = target_q;
        drawn_d    = drawn_q;
        walk_start = 1'b0;
        diff       = sync2_q ^ drawn_q;
        case (state_q)
            INIT: begin
                if (wlast) begin
                    if (k_q == K_W'(NUM_KEYS - 1)) begin
                        state_d = SCAN;
                        drawn_d = '0;
                    end else begin
                        k_d        = k_q + K_W'(1);
                        walk_start = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (diff != '0) begin
                    // Downward scan so the lowest-index changed key wins.
                    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
                        if (diff[i-1]) begin
                            k_d      = K_W'(i - 1);
                            target_d = sync2_q[i-1];
                        end
                    end
                    state_d    = DRAW;
                    walk_start = 1'b1;
                end
            end
            DRAW: begin
                if (wlast) begin
                    drawn_d[k_q] = target_q;
                    state_d      = SCAN;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign drawing   = (state_q != SCAN);
    assign walk_step = drawing;

    always_comb begin
        fill = (state_q == DRAW && target_q) ? PRESS_COLOUR : IDLE_COLOUR;
`ifdef KEY_RENDER_BORDER_EN
        border_pix = (wx == origin_cur);
`else
        border_pix = 1'b0;
`endif
        plot_d   = drawing;
        busy_d   = drawing || (state_d != SCAN);
        x_d      = drawing ? wx : x_q;
        y_d      = drawing ? wy : y_q;
        colour_d = colour_q;
        if (drawing) colour_d = border_pix ? BORDER_COLOUR : fill;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            sync1_q  <= '0;
            sync2_q  <= '0;
            drawn_q  <= '0;
            k_q      <= '0;
            target_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            sync1_q  <= keys;
            sync2_q  <= sync1_q;
            drawn_q  <= drawn_d;
            k_q      <= k_d;
            target_q <= target_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_key_renderer.sv
// Self-checking bench for key_renderer: records every plotted pixel into a
// screen model and compares it with the image implied by the key states.
module tb_key_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] keys;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int px;
        int py;
        int c;
    } pix_t;

    pix_t     q[$];
    logic [2:0] scr  [0:159][0:119];
    int       hits [0:159][0:119];
    int       cyc_n = 0;

    key_renderer dut (
        .clock  (clock),
        .reset  (reset),
        .keys   (keys),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc_n++;
        if (plot === 1'b1) begin
            q.push_back('{cyc_n, int'(x), int'(y), int'(colour)});
            if (x < 8'd160 && y < 7'd120) begin
                scr[x][y] = colour;
                hits[x][y]++;
            end
        end
    end

    function automatic logic [2:0] exp_col(int px, int py, logic [3:0] kv);
        logic [2:0] c;
        int k;
        k = px / 40;
        c = kv[k] ? 3'b010 : 3'b111;
`ifdef KEY_RENDER_BORDER_EN
        if (px % 40 == 0) c = 3'b000;
`endif
        if (py < 10 || py > 109) c = 3'bxxx;
        return c;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        q.delete();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                hits[i][j] = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (4) @(posedge clock);
        #1;
        while (!(busy === 1'b0 && plot === 1'b0) && n < 25000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_idle_in_time"}, int'(n < 25000), 1);
    endtask

    task automatic wait_plots(input int cnt, input string tag);
        int n = 0;
        while (q.size() < cnt && n < 25000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_plots_in_time"}, int'(n < 25000), 1);
    endtask

    task automatic cmp_screen(input string tag, input logic [3:0] kv);
        int badpx = 0;
        for (int px = 0; px < 160; px++)
            for (int py = 0; py < 120; py++) begin
                if (py >= 10 && py <= 109) begin
                    if (scr[px][py] !== exp_col(px, py, kv)) badpx++;
                end else if (hits[px][py] != 0) begin
                    badpx++;
                end
            end
        check({tag, "_screen_bad_pixels"}, badpx, 0);
    endtask

    task automatic init_checks(input string tag);
        int badhit = 0;
        check({tag, "_plot_count"}, q.size(), 16000);
        for (int px = 0; px < 160; px++)
            for (int py = 10; py <= 109; py++)
                if (hits[px][py] != 1) badhit++;
        check({tag, "_hit_once"}, badhit, 0);
        cmp_screen(tag, 4'b0000);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_plot_after"}, int'(plot), 0);
    endtask

    initial begin
        logic [3:0] cur, nk;
        int nbad;

        reset = 1'b1;
        keys  = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 1);

        clear_rec();
        reset = 1'b0;
        wait_idle("init1");
        init_checks("init1");

        // Two keys changing together: key0 then key3, one idle cycle between.
        clear_rec();
        keys = 4'b1001;
        wait_idle("k1001");
        check("k1001_count", q.size(), 8000);
        if (q.size() >= 8000) begin
            check("k1001_first_x", q[0].px, 0);
            check("k1001_first_y", q[0].py, 10);
            check("k1001_first_colour", q[0].c, int'(exp_col(0, 10, 4'b1001)));
            check("k1001_end0_x", q[3999].px, 39);
            check("k1001_end0_y", q[3999].py, 109);
            check("k1001_gap", q[4000].cyc - q[3999].cyc, 2);
            check("k1001_second_x", q[4000].px, 120);
            check("k1001_last_x", q[7999].px, 159);
        end
        cmp_screen("k1001", 4'b1001);

        // Latency from a key change to the first plot while idle.
        clear_rec();
        keys = 4'b1101;
        for (int e = 0; e < 3; e++) begin
            @(posedge clock);
            #1;
            check("lat_plot_low", int'(plot), 0);
        end
        @(posedge clock);
        #1;
        check("lat_plot_high", int'(plot), 1);
        check("lat_x", int'(x), 80);
        check("lat_y", int'(y), 10);
        check("lat_colour", int'(colour), int'(exp_col(80, 10, 4'b1101)));
        wait_idle("k2");
        check("k2_count", q.size(), 4000);
        nbad = 0;
        foreach (q[i]) if (q[i].px < 80 || q[i].px > 119) nbad++;
        check("k2_x_range", nbad, 0);
        cmp_screen("k2", 4'b1101);

        // Release during the key's own redraw: complete green, then repaint white.
        clear_rec();
        keys = 4'b1111;
        wait_plots(1000, "k1_press");
        keys = 4'b1101;
        wait_idle("k1_release");
        check("k1_count", q.size(), 8000);
        nbad = 0;
        foreach (q[i]) begin
            if (q[i].px < 40 || q[i].px > 79) nbad++;
            else if (i < 4000 && q[i].c != int'(exp_col(q[i].px, q[i].py, 4'b1111))) nbad++;
            else if (i >= 4000 && q[i].c != int'(exp_col(q[i].px, q[i].py, 4'b1101))) nbad++;
        end
        check("k1_sequence_bad", nbad, 0);
        cmp_screen("k1", 4'b1101);

        // Random single-key toggles against the screen model.
        cur = 4'b1101;
        for (int r = 0; r < 4; r++) begin
            nk = cur ^ (4'b0001 << $urandom_range(0, 3));
            clear_rec();
            keys = nk;
            wait_idle("rnd");
            check("rnd_count", q.size(), 4000 * $countones(nk ^ cur));
            cmp_screen("rnd", nk);
            cur = nk;
        end

        // Asynchronous reset in the middle of a redraw, then full INIT again.
        clear_rec();
        keys = cur ^ 4'b0100;
        wait_plots(2000, "mid");
        reset = 1'b1;
        #1;
        check("mid_rst_plot", int'(plot), 0);
        check("mid_rst_busy", int'(busy), 1);
        keys = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        clear_rec();
        reset = 1'b0;
        wait_idle("init2");
        init_checks("init2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
